// File: rtl/div_16x8_seq_if.sv
// Handshake bundle for div_16x8_seq: operand request channel and result channel.
// master drives operands and out_ready; slave is the divider.
interface div_16x8_seq_if #(
    parameter int unsigned DW_N = 16,
    parameter int unsigned DW_D = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional approximate mode: define DIV_APPROX_EN to skip the APPROX_K low quotient bits
// (quotient low bits forced to 0, latency DW_N-APPROX_K). Divide-by-zero returns
// quotient all ones, remainder = dividend low bits, div_by_zero = 1.
module div_16x8_seq #(
    parameter int unsigned DW_N     = 16,
    parameter int unsigned DW_D     = 8,
    parameter int unsigned APPROX_K = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    div_16x8_seq_if.slave bus
);

`ifdef DIV_APPROX_EN
    localparam int unsigned SKIP = APPROX_K;
`else
    localparam int unsigned SKIP = 0;
`endif
    localparam int unsigned STEPS = DW_N - SKIP;
    localparam int unsigned CW    = $clog2(DW_N);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (APPROX_K >= DW_N) begin : g_bad_approx_k
        $error("APPROX_K must be below DW_N");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW_D-1:0] p;      // partial remainder, always < divisor between steps
    logic [DW_N-1:0] acc;    // dividend bits shift out the top, quotient bits shift in below
    logic [DW_D-1:0] dreg;

    logic [DW_D:0]   p_sh;
    logic            ge;
    logic [DW_D-1:0] p_nx;
    logic [DW_N-1:0] acc_nx;

    // One restoring step: shift in next dividend bit, subtract divisor if it fits.
    always_comb begin
        p_sh   = {p, acc[DW_N-1]};
        ge     = (p_sh >= {1'b0, dreg});
        p_nx   = ge ? DW_D'(p_sh - {1'b0, dreg}) : p_sh[DW_D-1:0];
        acc_nx = {acc[DW_N-2:0], ge};
    end

    // Control FSM with registered handshake and result outputs.
    // After STEPS shifts acc holds {unused dividend low bits, quotient bits}; shifting left by
    // SKIP yields the quotient with zeroed low bits (identity when SKIP is 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            p               <= '0;
            acc             <= '0;
            dreg            <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc          <= bus.dividend;
                        dreg         <= bus.divisor;
                        p            <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= (bus.divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    p   <= p_nx;
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state           <= DONE;
                        bus.out_valid   <= 1'b1;
                        bus.quotient    <= acc_nx << SKIP;
                        bus.remainder   <= p_nx;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (!bus.out_valid) begin
                        // Only the divide-by-zero path arrives here without a result yet.
                        bus.out_valid   <= 1'b1;
                        bus.quotient    <= '1;
                        bus.remainder   <= acc[DW_D-1:0];
                        bus.div_by_zero <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed self-checking bench for div_16x8_seq (exact mode by default; expectations
// switch when DIV_APPROX_EN is defined, with APPROX_K = 4).
module tb_div_16x8_seq;

    localparam int unsigned DW_N = 16;
    localparam int unsigned DW_D = 8;
`ifdef DIV_APPROX_EN
    localparam int unsigned K   = 4;
`else
    localparam int unsigned K   = 0;
`endif
    localparam int unsigned LAT = DW_N - K;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_16x8_seq_if #(.DW_N(DW_N), .DW_D(DW_D)) bus ();

    div_16x8_seq #(.DW_N(DW_N), .DW_D(DW_D), .APPROX_K(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands and wait for the accepting edge; returns edges spent.
    task automatic send(input logic [15:0] n, input logic [7:0] d, output int edges);
        edges        = 0;
        bus.in_valid = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        while (!bus.in_ready && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
        @(posedge clk); #1;
        edges++;
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen (bounded).
    task automatic wait_out(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.quotient !== 16'd0) begin errors++; $display("FAIL rst_quotient got %0d want 0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL rst_remainder got %0d want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_dbz got %b want 0", bus.div_by_zero); end
    endtask

    task automatic test_basic;
        int e, lat;
        logic [15:0] eq;
        eq = (K == 0) ? 16'd142 : 16'd128;
        bus.out_ready = 1'b1;
        send(16'd1000, 8'd7, e);
        wait_out(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL basic_quotient got %0d want %0d", bus.quotient, eq); end
        checks++; if (bus.remainder !== 8'd6) begin errors++; $display("FAIL basic_remainder got %0d want 6", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", bus.div_by_zero); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_after_hs got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.quotient !== eq || bus.remainder !== 8'd6) begin errors++; $display("FAIL basic_idle_hold got %0d/%0d want %0d/6", bus.quotient, bus.remainder, eq); end
    endtask

    task automatic test_corners;
        logic [15:0] tn [3];
        logic [7:0]  td [3];
        logic [15:0] tq [3];
        logic [7:0]  tr [3];
        int e, lat;
        tn[0] = 16'd65535; td[0] = 8'd1;
        tn[1] = 16'd0;     td[1] = 8'd255;
        tn[2] = 16'd300;   td[2] = 8'd255;
        if (K == 0) begin
            tq[0] = 16'd65535; tr[0] = 8'd0;
            tq[1] = 16'd0;     tr[1] = 8'd0;
            tq[2] = 16'd1;     tr[2] = 8'd45;
        end else begin
            tq[0] = 16'd65520; tr[0] = 8'd0;
            tq[1] = 16'd0;     tr[1] = 8'd0;
            tq[2] = 16'd0;     tr[2] = 8'd18;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(tn[i], td[i], e);
            wait_out(lat);
            checks++;
            if (lat !== LAT || bus.quotient !== tq[i] || bus.remainder !== tr[i] || bus.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL corner_%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d dbz=0",
                         i, lat, bus.quotient, bus.remainder, bus.div_by_zero, LAT, tq[i], tr[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int e, lat;
        bus.out_ready = 1'b1;
        send(16'd5, 8'd0, e);
        wait_out(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
        checks++; if (bus.quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz_quotient got %h want ffff", bus.quotient); end
        checks++; if (bus.remainder !== 8'd5) begin errors++; $display("FAIL dbz_remainder got %0d want 5", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", bus.div_by_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold;
        int e, lat;
        logic [15:0] eq, eq2;
        logic [7:0]  er2;
        eq  = (K == 0) ? 16'd142 : 16'd128;
        eq2 = (K == 0) ? 16'd6 : 16'd0;
        er2 = (K == 0) ? 8'd2 : 8'd1;
        bus.out_ready = 1'b0;
        send(16'd1000, 8'd7, e);
        wait_out(lat);
        bus.in_valid = 1'b1;
        bus.dividend = 16'd20;
        bus.divisor  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== eq || bus.remainder !== 8'd6) begin
                errors++;
                $display("FAIL hold_cycle_%0d got ov=%b ir=%b q=%0d r=%0d want ov=1 ir=0 q=%0d r=6",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, eq);
            end
        end
        bus.out_ready = 1'b1;
        send(16'd20, 8'd3, e);
        checks++; if (e !== 2) begin errors++; $display("FAIL hold_accept_edges got %0d want 2", e); end
        wait_out(lat);
        checks++;
        if (lat !== LAT || bus.quotient !== eq2 || bus.remainder !== er2) begin
            errors++;
            $display("FAIL hold_next got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d", lat, bus.quotient, bus.remainder, LAT, eq2, er2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int e, lat;
        logic seen;
        logic [15:0] eq2;
        logic [7:0]  er2;
        eq2 = (K == 0) ? 16'd6 : 16'd0;
        er2 = (K == 0) ? 8'd2 : 8'd1;
        bus.out_ready = 1'b1;
        send(16'd1000, 8'd7, e);
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 16'd0 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got ov=%b ir=%b q=%0d r=%0d dbz=%b want 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse got 1 want 0"); end
        send(16'd20, 8'd3, e);
        wait_out(lat);
        checks++;
        if (lat !== LAT || bus.quotient !== eq2 || bus.remainder !== er2 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fresh got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d", lat, bus.quotient, bus.remainder, LAT, eq2, er2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int e, lat;
        bus.out_ready = 1'b1;
        send(16'd777, 8'd9, e);
        wait_out(lat);
        send(16'd4660, 8'd200, e);
        checks++; if (lat + e !== LAT + 2) begin errors++; $display("FAIL b2b_interval got %0d want %0d", lat + e, LAT + 2); end
        wait_out(lat);
        checks++;
        if (bus.quotient !== (((16'd4660 >> K) / 16'd200) << K) || bus.remainder !== 8'(((16'd4660 >> K) % 16'd200))) begin
            errors++;
            $display("FAIL b2b_second got q=%0d r=%0d", bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        int e, lat;
        logic [15:0] n, xq;
        logic [7:0]  d, xr;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 16'($urandom);
            d = 8'($urandom_range(1, 255));
            xq = ((n >> K) / {8'd0, d}) << K;
            xr = 8'((n >> K) % {8'd0, d});
            send(n, d, e);
            wait_out(lat);
            checks++;
            if (bus.quotient !== xq || bus.remainder !== xr) begin
                errors++;
                $display("FAIL sweep_%0d n=%0d d=%0d got q=%0d r=%0d want q=%0d r=%0d", i, n, d, bus.quotient, bus.remainder, xq, xr);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic;
        test_corners;
        test_div_zero;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
